// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter that shares one asynchronous register-file RAM between two
// request ports and sequences CS/OE/WS and the tristate DATA bus for each access.
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_cs,
  output logic                  ram_oe,
  output logic                  ram_ws,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);

  typedef enum logic [2:0] {
    IDLE,
    W_SETUP,
    W_STROBE,
    W_HOLD,
    R_ENABLE,
    R_CAPTURE
  } state_t;

  state_t                state, state_nxt;
  logic                  pri;
  logic                  port_q;
  logic                  grant, winner, win_we;
  logic                  ack_nxt;
  logic                  cs_nxt, oe_nxt, ws_nxt, drv_nxt;
  logic                  cs_q, oe_q, ws_q, drv_q;
  logic                  ack0_q, ack1_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  always_comb begin
    grant     = req0 | req1;
    winner    = (req0 & req1) ? pri : req1;
    win_we    = winner ? we1 : we0;
    state_nxt = state;
    case (state)
      IDLE:      if (grant) state_nxt = win_we ? W_SETUP : R_ENABLE;
      W_SETUP:   state_nxt = W_STROBE;
      W_STROBE:  state_nxt = W_HOLD;
      W_HOLD:    state_nxt = IDLE;
      R_ENABLE:  state_nxt = R_CAPTURE;
      R_CAPTURE: state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // RAM pins are registered from the next state so CS/OE/WS never glitch.
  always_comb begin
    cs_nxt  = 1'b1;
    oe_nxt  = 1'b0;
    ws_nxt  = 1'b0;
    drv_nxt = 1'b0;
    ack_nxt = (state == W_STROBE) || (state == R_CAPTURE);
    case (state_nxt)
      W_SETUP, W_HOLD: begin
        cs_nxt  = 1'b0;
        drv_nxt = 1'b1;
      end
      W_STROBE: begin
        cs_nxt  = 1'b0;
        ws_nxt  = 1'b1;
        drv_nxt = 1'b1;
      end
      R_ENABLE, R_CAPTURE: begin
        cs_nxt = 1'b0;
        oe_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pri     <= 1'b0;
      port_q  <= 1'b0;
      addr_q  <= '0;
      rdata_q <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      cs_q    <= 1'b1;
      oe_q    <= 1'b0;
      ws_q    <= 1'b0;
      drv_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cs_q   <= cs_nxt;
      oe_q   <= oe_nxt;
      ws_q   <= ws_nxt;
      drv_q  <= drv_nxt;
      ack0_q <= ack_nxt & ~port_q;
      ack1_q <= ack_nxt & port_q;
      if (state == IDLE && grant) begin
        pri    <= ~winner;
        port_q <= winner;
        addr_q <= winner ? addr1 : addr0;
      end
      if (state == R_CAPTURE) rdata_q <= ram_data;
    end
  end

  // Write data only matters while drv_q is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && grant) wdata_q <= winner ? wdata1 : wdata0;
  end

  assign ram_data = drv_q ? wdata_q : 'z;
  assign ram_addr = addr_q;
  assign ram_cs   = cs_q;
  assign ram_oe   = oe_q;
  assign ram_ws   = ws_q;
  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign rdata    = rdata_q;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: async RAM model, transaction-timing reference model,
// vector table, contention/fairness/reset sequences and randomized two-port traffic.
module tb_ram_port_arbiter;

  localparam int DW = 8;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_v   [2];
  logic          we_v    [2];
  logic [AW-1:0] addr_v  [2];
  logic [DW-1:0] wdata_v [2];
  logic          ack0, ack1, busy, ram_cs, ram_oe, ram_ws;
  logic [DW-1:0] rdata;
  logic [AW-1:0] ram_addr;
  wire  [DW-1:0] ram_data;

  int n_checks = 0;
  int n_errors = 0;

  ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req_v[0]), .req1(req_v[1]),
    .we0(we_v[0]), .we1(we_v[1]),
    .addr0(addr_v[0]), .addr1(addr_v[1]),
    .wdata0(wdata_v[0]), .wdata1(wdata_v[1]),
    .ack0(ack0), .ack1(ack1),
    .rdata(rdata), .busy(busy),
    .ram_addr(ram_addr), .ram_cs(ram_cs), .ram_oe(ram_oe), .ram_ws(ram_ws),
    .ram_data(ram_data)
  );

  always #5 clk = ~clk;

  // Asynchronous register-file RAM: drives DATA when selected with OE, writes on WS rise.
  logic [DW-1:0] ram_mem [2**AW];
  int ws_count = 0;
  assign ram_data = (!ram_cs && ram_oe) ? ram_mem[ram_addr] : 'z;
  initial begin
    for (int i = 0; i < 2**AW; i++) ram_mem[i] = '0;
    forever begin
      @(posedge ram_ws);
      ws_count++;
      if (!ram_cs) ram_mem[ram_addr] = ram_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one transaction at a time; a write keeps the RAM busy for three
  // cycles after the grant, a read for two; ACK lands three cycles after the grant.
  logic [DW-1:0] ref_mem [2**AW];
  int            cyc = 0;
  int            busy_until = -1;
  int            grant_cyc = -10;
  int            ack_cyc = -10;
  int            cur_port = 0;
  logic          pri_m = 1'b0;
  logic          cur_we = 1'b0;
  logic [AW-1:0] cur_addr = '0;
  logic [DW-1:0] cur_wdata = '0;
  logic [DW-1:0] pend_rd = '0;
  logic [DW-1:0] rdata_exp = '0;

  initial begin
    int w;
    for (int i = 0; i < 2**AW; i++) ref_mem[i] = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        busy_until = -1;
        grant_cyc  = -10;
        ack_cyc    = -10;
        pri_m      = 1'b0;
        cur_we     = 1'b0;
        rdata_exp  = '0;
        cyc++;
      end else begin
        if (cyc > busy_until && (req_v[0] || req_v[1])) begin
          if (req_v[0] && req_v[1]) w = int'(pri_m);
          else w = req_v[1] ? 1 : 0;
          pri_m      = (w == 0);
          cur_port   = w;
          cur_we     = we_v[w];
          cur_addr   = addr_v[w];
          cur_wdata  = wdata_v[w];
          grant_cyc  = cyc;
          busy_until = cyc + (cur_we ? 3 : 2);
          ack_cyc    = cyc + 3;
          if (!cur_we) pend_rd = ref_mem[cur_addr];
        end
        cyc++;
        if (cur_we && cyc == grant_cyc + 2) ref_mem[cur_addr] = cur_wdata;
        if (!cur_we && cyc == ack_cyc) rdata_exp = pend_rd;
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  initial begin
    logic       busy_e;
    logic [5:0] exp_ctl;
    int         ph;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        busy_e  = (cyc <= busy_until);
        ph      = cyc - grant_cyc;
        exp_ctl = {busy_e, !busy_e, busy_e && !cur_we, busy_e && cur_we && ph == 2,
                   cyc == ack_cyc && cur_port == 1, cyc == ack_cyc && cur_port == 0};
        check("ctl{busy,cs,oe,ws,ack1,ack0}",
              32'({busy, ram_cs, ram_oe, ram_ws, ack1, ack0}), 32'(exp_ctl));
        check("rdata_hold", 32'(rdata), 32'(rdata_exp));
        if (busy_e) check("ram_addr", 32'(ram_addr), 32'(cur_addr));
        if (busy_e && cur_we) check("ram_data_drive", 32'(ram_data), 32'(cur_wdata));
      end
    end
  end

  int ack_order[$];

  task automatic do_req(input int p, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int lat, output logic [DW-1:0] rd);
    lat = -1;
    rd  = '0;
    @(negedge clk);
    #1;
    req_v[p] = 1'b1; we_v[p] = we; addr_v[p] = a; wdata_v[p] = d;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if ((p == 0) ? ack0 : ack1) begin
        lat = i;
        rd  = rdata;
        ack_order.push_back(p);
        break;
      end
    end
    #1;
    req_v[p] = 1'b0;
    we_v[p] = 1'($urandom); addr_v[p] = AW'($urandom); wdata_v[p] = DW'($urandom);
    if (lat < 0) check($sformatf("ack_timeout_p%0d", p), 32'(lat), 32'd1);
  endtask

  task automatic wait_until(input int which);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      hit = (which == 0) ? busy : (which == 1) ? ram_ws : ram_oe;
      if (hit) break;
    end
    if (!hit) check($sformatf("wait_timeout_%0d", which), 32'(hit), 32'd1);
  endtask

  task automatic reset_now_and_check(input string tag);
    #1;
    rst_n = 1'b0;
    req_v[0] = 1'b0;
    req_v[1] = 1'b0;
    #1;
    check({tag, "_ctl"}, 32'({busy, ram_cs, ram_oe, ram_ws, ack1, ack0}), 32'b010000);
    check({tag, "_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_rdata"}, 32'(rdata), 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    int            port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t          tbl [10];
  int            lat0, lat1, la, lb, ws0;
  logic [DW-1:0] rd0, rd1, ra, rb;

  initial begin
    tbl[0] = '{0, 1'b1, 5'h03, 8'hA5, 8'h00};
    tbl[1] = '{0, 1'b0, 5'h03, 8'h00, 8'hA5};
    tbl[2] = '{1, 1'b1, 5'h0A, 8'h5A, 8'h00};
    tbl[3] = '{1, 1'b0, 5'h0A, 8'h00, 8'h5A};
    tbl[4] = '{0, 1'b0, 5'h1F, 8'h00, 8'h22};
    tbl[5] = '{1, 1'b1, 5'h1F, 8'hFF, 8'h00};
    tbl[6] = '{0, 1'b0, 5'h1F, 8'h00, 8'hFF};
    tbl[7] = '{1, 1'b0, 5'h00, 8'h00, 8'h11};
    tbl[8] = '{0, 1'b1, 5'h07, 8'hC3, 8'h00};
    tbl[9] = '{1, 1'b0, 5'h07, 8'h00, 8'hC3};

    for (int p = 0; p < 2; p++) begin
      req_v[p] = 1'b0; we_v[p] = 1'b0; addr_v[p] = '0; wdata_v[p] = '0;
    end

    repeat (3) @(negedge clk);
    check("reset_ctl", 32'({busy, ram_cs, ram_oe, ram_ws, ack1, ack0}), 32'b010000);
    check("reset_addr", 32'(ram_addr), 32'd0);
    check("reset_rdata", 32'(rdata), 32'd0);
    #1 rst_n = 1'b1;

    // Contention straight out of reset: port 0 first, port 1 right after its IDLE.
    fork
      do_req(0, 1'b1, 5'h00, 8'h11, lat0, rd0);
      do_req(1, 1'b1, 5'h1F, 8'h22, lat1, rd1);
    join
    check("contend_lat_p0", 32'(lat0), 32'd3);
    check("contend_lat_p1", 32'(lat1), 32'd7);
    do_req(0, 1'b0, 5'h00, 8'h00, lat0, rd0);
    check("contend_rd_p0", 32'(rd0), 32'h11);
    do_req(1, 1'b0, 5'h1F, 8'h00, lat1, rd1);
    check("contend_rd_p1", 32'(rd1), 32'h22);

    // Fairness: both ports keep requesting writes.
    @(negedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    ack_order.delete();
    fork
      begin
        for (int i = 0; i < 3; i++) do_req(0, 1'b1, AW'(8 + i), DW'(16 + i), la, ra);
      end
      begin
        for (int j = 0; j < 3; j++) do_req(1, 1'b1, AW'(11 + j), DW'(32 + j), lb, rb);
      end
    join
    check("fair_count", 32'(ack_order.size()), 32'd6);
    for (int k = 0; k < 6 && k < ack_order.size(); k++)
      check($sformatf("fair_order_%0d", k), 32'(ack_order[k]), 32'(k % 2));

    for (int i = 0; i < 10; i++) begin
      ws0 = ws_count;
      do_req(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, la, ra);
      check($sformatf("tbl%0d_lat", i), 32'(la), 32'd3);
      check($sformatf("tbl%0d_ws_rises", i), 32'(ws_count - ws0), tbl[i].we ? 32'd1 : 32'd0);
      if (!tbl[i].we) check($sformatf("tbl%0d_rdata", i), 32'(ra), 32'(tbl[i].exp_rd));
    end

    // Late request: port 1 arrives while port 0's write is in progress.
    fork
      do_req(0, 1'b1, 5'h10, 8'h3C, lat0, rd0);
      begin
        @(negedge clk);
        do_req(1, 1'b0, 5'h00, 8'h00, lat1, rd1);
      end
    join
    check("late_lat_p0", 32'(lat0), 32'd3);
    check("late_lat_p1", 32'(lat1), 32'd6);
    check("late_rd_p1", 32'(rd1), 32'h11);

    // Reset during W_SETUP: the write must not happen.
    @(negedge clk);
    #1;
    req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 5'h06; wdata_v[0] = 8'h77;
    wait_until(0);
    reset_now_and_check("rst_setup");
    do_req(0, 1'b0, 5'h06, 8'h00, la, ra);
    check("rst_setup_read", 32'(ra), 32'h00);

    // Reset during W_STROBE: old or new value, nothing else.
    @(negedge clk);
    #1;
    req_v[1] = 1'b1; we_v[1] = 1'b1; addr_v[1] = 5'h05; wdata_v[1] = 8'h5A;
    wait_until(1);
    reset_now_and_check("rst_strobe");
    do_req(1, 1'b0, 5'h05, 8'h00, la, ra);
    check("rst_strobe_read_old_or_new", 32'(ra == 8'h5A || ra == 8'h00), 32'd1);

    // Reset during R_ENABLE: RDATA stays at its reset value and no ACK appears.
    @(negedge clk);
    #1;
    req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 5'h03;
    wait_until(2);
    reset_now_and_check("rst_read");
    repeat (3) begin
      @(negedge clk);
      check("rst_read_no_ack", 32'({ack1, ack0}), 32'd0);
      check("rst_read_rdata", 32'(rdata), 32'd0);
    end

    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          do_req(0, 1'($urandom), AW'($urandom), DW'($urandom), la, ra);
        end
      end
      begin
        for (int j = 0; j < 40; j++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          do_req(1, 1'($urandom), AW'($urandom), DW'($urandom), lb, rb);
        end
      end
    join

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 1000000", $time);
    $fatal(1, "watchdog");
  end

endmodule
